// File: rtl/chan_readout_arb.sv
// Round-robin arbiter and stream mux sharing one readout path among
// 2**SIZE channel buffers.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   req[N]                 per-channel request (level)
//   ch_data[N*DW]          channel k at [k*DW +: DW]
//   ch_valid/ch_last[N]    per-channel stream qualifiers
//   ch_ready[N]            per-channel ready (granted bit only)
//   out_data/valid/last    muxed stream toward the readout FIFO
//   out_ready              downstream ready
//   gnt[N], gnt_id[SIZE]   registered grant, one-hot and binary
//   busy                   high while a grant is active
module chan_readout_arb #(
    parameter int SIZE      = 3,
    parameter int DW        = 16,
    parameter int MAX_BURST = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2**SIZE-1:0]       req,
    input  logic [(2**SIZE)*DW-1:0]  ch_data,
    input  logic [2**SIZE-1:0]       ch_valid,
    input  logic [2**SIZE-1:0]       ch_last,
    output logic [2**SIZE-1:0]       ch_ready,
    output logic [DW-1:0]            out_data,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [2**SIZE-1:0]       gnt,
    output logic [SIZE-1:0]          gnt_id,
    output logic                     busy
);

    localparam int N  = 2**SIZE;
    localparam int CW = $clog2(MAX_BURST + 1);

    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;

    logic [0:0]      state;
    logic [SIZE-1:0] ptr;
    logic [CW-1:0]   beat_cnt;

    logic [SIZE-1:0] scan;
    logic [SIZE-1:0] win_id;
    logic            win_hit;

    logic            burst_end;
    logic            beat;

    // Scan upward from ptr+1; the SIZE-bit add wraps modulo N,
    // so i == N lands back on ptr itself (lowest priority).
    always_comb begin
        scan    = '0;
        win_id  = '0;
        win_hit = 1'b0;
        for (int i = 1; i <= N; i++) begin
            scan = ptr + SIZE'(i);
            if (!win_hit && req[scan]) begin
                win_hit = 1'b1;
                win_id  = scan;
            end
        end
    end

    assign busy      = (state == XFER);
    assign burst_end = (beat_cnt == LAST_BEAT);

    assign out_data  = busy ? ch_data[int'(gnt_id)*DW +: DW] : '0;
    assign out_valid = busy & ch_valid[gnt_id];
    assign out_last  = out_valid & (ch_last[gnt_id] | burst_end);
    assign beat      = out_valid & out_ready;

    always_comb begin
        ch_ready = '0;
        if (busy) begin
            ch_ready[gnt_id] = out_ready;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '1;
            gnt      <= '0;
            gnt_id   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_hit) begin
                        state    <= XFER;
                        ptr      <= win_id;
                        gnt      <= N'(1) << win_id;
                        gnt_id   <= win_id;
                        beat_cnt <= '0;
                    end
                end
                XFER: begin
                    if (beat) begin
                        if (out_last) begin
                            // gnt_id is kept; outputs are gated by busy
                            state    <= IDLE;
                            gnt      <= '0;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule
